// File: rtl/rk8e_dma.sv
// RK8E data-break sequencer: turns a disk transfer command into single-word
// data-break cycles, buffering words in a small FIFO between disk and memory.
module rk8e_dma #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned FULL_WC    = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_start,
   input  logic        cmd_to_disk,
   input  logic        cmd_half,
   input  logic [2:0]  cmd_field,
   input  logic [11:0] cmd_addr,
   input  logic [11:0] dsk_wdata,
   input  logic        dsk_wvalid,
   output logic        dsk_wready,
   output logic [11:0] dsk_rdata,
   output logic        dsk_rvalid,
   input  logic        dsk_rready,
   output logic        data_break,
   output logic [14:0] dmaAddr,
   output logic [11:0] disk2mem,
   output logic        to_disk,
   input  logic        db_done,
   input  logic [11:0] mem2disk,
   output logic        busy,
   output logic        done,
   output logic [11:0] cur_addr
);

   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = PW + 1;
   localparam int unsigned CW   = $clog2(FULL_WC) + 1;

   localparam logic [CW-1:0]   FULL_LEN  = CW'(FULL_WC);
   localparam logic [CW-1:0]   HALF_LEN  = CW'(FULL_WC / 2);
   localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ARM   = 3'd1;
   localparam logic [2:0] REQ   = 3'd2;
   localparam logic [2:0] ADV   = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;
   localparam logic [2:0] FIN   = 3'd5;

   logic [2:0]      state_q, state_d;
   logic            dir_q;
   logic [2:0]      field_q;
   logic [11:0]     cur_addr_q;
   logic [CW-1:0]   rem_q;
   logic [CW-1:0]   len_q;
   logic [CW-1:0]   acc_q;

   logic [11:0]     fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CNTW-1:0] cnt_q;

   logic            in_req, brk_done, fifo_empty, fifo_full;
   logic            wr_fire, rd_fire, push, pop;
   logic [11:0]     push_data, fifo_head;

   always_comb begin
      in_req     = (state_q == REQ);
      brk_done   = in_req & db_done;
      fifo_empty = (cnt_q == '0);
      fifo_full  = (cnt_q == DEPTH_CNT);
      fifo_head  = fifo_mem[rd_ptr_q];

      busy       = (state_q != IDLE);
      done       = (state_q == FIN);
      to_disk    = busy & dir_q;
      data_break = in_req;
      dmaAddr    = in_req ? {field_q, cur_addr_q} : 15'd0;
      disk2mem   = (in_req & ~dir_q) ? fifo_head : 12'd0;
      cur_addr   = cur_addr_q;

      // A break completing this cycle frees a slot, so a full FIFO may still accept.
      dsk_wready = busy & ~dir_q & (~fifo_full | brk_done) & (acc_q < len_q);
      dsk_rvalid = to_disk & ~fifo_empty;
      dsk_rdata  = dsk_rvalid ? fifo_head : 12'd0;

      wr_fire    = dsk_wvalid & dsk_wready;
      rd_fire    = dsk_rvalid & dsk_rready;
      push       = dir_q ? brk_done : wr_fire;
      pop        = dir_q ? rd_fire : brk_done;
      push_data  = dir_q ? mem2disk : dsk_wdata;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_start) state_d = ARM;
         ARM:     if (dir_q ? ~fifo_full : ~fifo_empty) state_d = REQ;
         REQ:     if (db_done) state_d = ADV;
         ADV:     state_d = (rem_q == CW'(1)) ? DRAIN : ARM;
         DRAIN:   if (~dir_q | fifo_empty) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         dir_q      <= 1'b0;
         field_q    <= 3'd0;
         cur_addr_q <= 12'd0;
         rem_q      <= '0;
         len_q      <= '0;
         acc_q      <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && cmd_start) begin
            dir_q      <= cmd_to_disk;
            field_q    <= cmd_field;
            cur_addr_q <= cmd_addr;
            rem_q      <= cmd_half ? HALF_LEN : FULL_LEN;
            len_q      <= cmd_half ? HALF_LEN : FULL_LEN;
            acc_q      <= '0;
         end else begin
            if (state_q == ADV) begin
               // 12-bit address wraps inside the field; field_q is never touched.
               cur_addr_q <= cur_addr_q + 12'd1;
               rem_q      <= rem_q - CW'(1);
            end
            if (wr_fire) acc_q <= acc_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNTW'(1);
            2'b01:   cnt_q <= cnt_q - CNTW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= push_data;
   end

endmodule
